// File: rtl/axis_mult_frame_gen_pkg.sv
// Shared constants for the multiplier stage and the stream-to-lite adapter.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: operand/product widths, default frame length, counter width,
//           and a helper sizing the frame index register.
package axis_mult_frame_gen_pkg;

    localparam int C_OP_WIDTH_DEF   = 16;
    localparam int C_PROD_WIDTH_DEF = 2 * C_OP_WIDTH_DEF;
    localparam int C_FRAME_LEN_DEF  = 16;
    localparam int C_CNT_WIDTH_DEF  = 32;

    // A frame length of 1 still needs a 1-bit index so the compare stays legal.
    function automatic int fidx_width(input int frame_len);
        return (frame_len > 1) ? $clog2(frame_len) : 1;
    endfunction

endpackage

// File: rtl/axis_mult_frame_gen_if.sv
// AXI-Stream bundle (tdata/tvalid/tready/tlast) shared by both sides of the multiplier.
// Latency: none, wires only.
// Backpressure: tready flows from slave to master.
// Modports: master drives tdata/tvalid/tlast, slave drives tready.
interface axis_mult_frame_gen_if #(
    parameter int W = 32
);
    logic [W-1:0] tdata;
    logic         tvalid;
    logic         tready;
    logic         tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_mult_frame_gen_pipe.sv
// Two-stage multiply pipe: S1 registers operands + last tag, S2 registers product + last tag.
// Latency: 2 enabled clocks from in_vld to out_vld.
// Backpressure: everything freezes while en=0; the caller derives en from the output side.
// Ports: clk, rst_n, en, in_vld/in_a/in_b/in_last -> out_vld/out_dat/out_last.
// Config: MULT_SIGNED_EN selects a two's-complement multiply, otherwise unsigned.
module axis_mult_frame_gen_pipe #(
    parameter int OW = 16,
    parameter int PW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          in_vld,
    input  logic [OW-1:0] in_a,
    input  logic [OW-1:0] in_b,
    input  logic          in_last,
    output logic          out_vld,
    output logic [PW-1:0] out_dat,
    output logic          out_last
);
    logic          v1;
    logic          l1;
    logic [OW-1:0] a1;
    logic [OW-1:0] b1;
    logic [PW-1:0] prod;

`ifdef MULT_SIGNED_EN
    // Sign-extend to full width first so the low PW bits are the exact signed product.
    assign prod = $signed({{OW{a1[OW-1]}}, a1}) * $signed({{OW{b1[OW-1]}}, b1});
`else
    assign prod = {{OW{1'b0}}, a1} * {{OW{1'b0}}, b1};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1       <= 1'b0;
            l1       <= 1'b0;
            a1       <= '0;
            b1       <= '0;
            out_vld  <= 1'b0;
            out_dat  <= '0;
            out_last <= 1'b0;
        end else if (en) begin
            v1       <= in_vld;
            l1       <= in_vld & in_last;   // tag only real words so tlast is 0 on bubbles
            a1       <= in_a;
            b1       <= in_b;
            out_vld  <= v1;
            out_dat  <= prod;
            out_last <= l1;
        end
    end

endmodule

// File: rtl/axis_mult_frame_gen.sv
// Pipelined multiplier s00 {b,a} -> m00 a*b, framed with tlast, plus word/frame telemetry.
// Latency: input handshake on edge k gives m00 tvalid after edge k+1 (no stall).
// Backpressure: s00 tready = !m00 tvalid | m00 tready; a stall freezes both stages.
// Ports: m00_axis_aclk, m00_axis_aresetn (async active-low), s00_axis (slave),
//        m00_axis (master), word_count, frame_count.
// Config: define MULT_SIGNED_EN for a signed multiply; default is unsigned.
module axis_mult_frame_gen
    import axis_mult_frame_gen_pkg::*;
#(
    parameter int C_OP_WIDTH             = C_OP_WIDTH_DEF,
    parameter int C_M00_AXIS_TDATA_WIDTH = C_PROD_WIDTH_DEF,
    parameter int C_FRAME_LEN            = C_FRAME_LEN_DEF,
    parameter int C_CNT_WIDTH            = C_CNT_WIDTH_DEF
) (
    input  logic                   m00_axis_aclk,
    input  logic                   m00_axis_aresetn,
    axis_mult_frame_gen_if.slave   s00_axis,
    axis_mult_frame_gen_if.master  m00_axis,
    output logic [C_CNT_WIDTH-1:0] word_count,
    output logic [C_CNT_WIDTH-1:0] frame_count
);
    localparam int FIDX_W = fidx_width(C_FRAME_LEN);

    logic                              en;
    logic                              in_hs;
    logic                              out_hs;
    logic                              last_tag;
    logic [FIDX_W-1:0]                 fidx;
    logic                              v2;
    logic                              l2;
    logic [C_M00_AXIS_TDATA_WIDTH-1:0] p2;

    assign en              = !v2 | m00_axis.tready;
    assign s00_axis.tready = en;
    assign in_hs           = s00_axis.tvalid & en;
    assign out_hs          = v2 & m00_axis.tready;
    assign last_tag        = (fidx == FIDX_W'(C_FRAME_LEN - 1)) | s00_axis.tlast;

    assign m00_axis.tvalid = v2;
    assign m00_axis.tdata  = p2;
    assign m00_axis.tlast  = l2;

    axis_mult_frame_gen_pipe #(
        .OW (C_OP_WIDTH),
        .PW (C_M00_AXIS_TDATA_WIDTH)
    ) u_pipe (
        .clk      (m00_axis_aclk),
        .rst_n    (m00_axis_aresetn),
        .en       (en),
        .in_vld   (in_hs),
        .in_a     (s00_axis.tdata[C_OP_WIDTH-1:0]),
        .in_b     (s00_axis.tdata[2*C_OP_WIDTH-1:C_OP_WIDTH]),
        .in_last  (last_tag),
        .out_vld  (v2),
        .out_dat  (p2),
        .out_last (l2)
    );

    // Early tlast from upstream closes the frame, so the next word restarts at index 0.
    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            fidx <= '0;
        end else if (in_hs) begin
            fidx <= last_tag ? '0 : fidx + FIDX_W'(1);
        end
    end

    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            word_count  <= '0;
            frame_count <= '0;
        end else if (out_hs) begin
            word_count <= word_count + 1'b1;
            if (l2) begin
                frame_count <= frame_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axis_mult_frame_gen.sv
// Directed bench for axis_mult_frame_gen: main DUT with frame length 4, plus a
// frame-length-1 instance fed the same operand stream with a permanently ready sink.
module tb_axis_mult_frame_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axis_mult_frame_gen_if #(.W(32)) s_if ();
    axis_mult_frame_gen_if #(.W(32)) m_if ();
    axis_mult_frame_gen_if #(.W(32)) s1_if ();
    axis_mult_frame_gen_if #(.W(32)) m1_if ();

    logic [31:0] word_count, frame_count, word_count1, frame_count1;

    axis_mult_frame_gen #(.C_OP_WIDTH(16), .C_M00_AXIS_TDATA_WIDTH(32), .C_FRAME_LEN(4), .C_CNT_WIDTH(32)) dut (
        .m00_axis_aclk    (clk),
        .m00_axis_aresetn (rst_n),
        .s00_axis         (s_if),
        .m00_axis         (m_if),
        .word_count       (word_count),
        .frame_count      (frame_count)
    );

    axis_mult_frame_gen #(.C_OP_WIDTH(16), .C_M00_AXIS_TDATA_WIDTH(32), .C_FRAME_LEN(1), .C_CNT_WIDTH(32)) dut1 (
        .m00_axis_aclk    (clk),
        .m00_axis_aresetn (rst_n),
        .s00_axis         (s1_if),
        .m00_axis         (m1_if),
        .word_count       (word_count1),
        .frame_count      (frame_count1)
    );

    assign s1_if.tdata  = s_if.tdata;
    assign s1_if.tvalid = s_if.tvalid;
    assign s1_if.tlast  = s_if.tlast;
    assign m1_if.tready = 1'b1;

    int n_chk = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic [31:0] q_dat[$];
    logic        q_last[$];
    int          q_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Inputs only change #1 after posedge, so a handshake seen at negedge completes at the next posedge.
    always @(negedge clk) begin
        if (rst_n && m_if.tvalid && m_if.tready) begin
            q_dat.push_back(m_if.tdata);
            q_last.push_back(m_if.tlast);
            q_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_q();
        q_dat.delete();
        q_last.delete();
        q_cyc.delete();
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tdata  = '0;
        m_if.tready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear_q();
    endtask

    task automatic send_word(input logic [15:0] a, input logic [15:0] b, input logic last);
        bit done = 0;
        s_if.tdata  = {b, a};
        s_if.tlast  = last;
        s_if.tvalid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (s_if.tready) begin
                @(posedge clk);
                #1;
                done = 1;
            end
        end
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        if (!done) chk("send_timeout", 0, 1);
    endtask

    task automatic wait_out(input int n);
        bit done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (q_dat.size() >= n) done = 1;
        end
        if (!done) chk("out_timeout", 64'(q_dat.size()), 64'(n));
        @(posedge clk);
        #1;
    endtask

    logic [31:0] exp_t2 [8] = '{32'd2, 32'd6, 32'd12, 32'd20, 32'd30, 32'd42, 32'd56, 32'd72};
    logic [31:0] held_dat;
    logic        held_last;
    logic [31:0] exp5;

    initial begin
        s_if.tvalid = 1'b0;
        s_if.tlast  = 1'b0;
        s_if.tdata  = '0;
        m_if.tready = 1'b1;

        // Reset state
        #2;
        chk("rst_tvalid", m_if.tvalid, 0);
        chk("rst_tlast", m_if.tlast, 0);
        chk("rst_tdata", m_if.tdata, 0);
        chk("rst_wc", word_count, 0);
        chk("rst_fc", frame_count, 0);
        do_reset();
        chk("rst_s_tready", s_if.tready, 1);

        // 1: single word, latency and count
        send_word(16'd5, 16'd3, 1'b0);
        @(negedge clk);
        chk("t1_not_yet", m_if.tvalid, 0);
        @(negedge clk);
        chk("t1_tvalid", m_if.tvalid, 1);
        chk("t1_tdata", m_if.tdata, 32'd15);
        chk("t1_tlast", m_if.tlast, 0);
        @(negedge clk);
        chk("t1_wc", word_count, 1);
        chk("t1_gone", m_if.tvalid, 0);

        // 2: 8 back-to-back words, frame length 4
        do_reset();
        for (int i = 0; i < 8; i++) send_word(16'(i + 1), 16'(i + 2), 1'b0);
        wait_out(8);
        chk("t2_count", 64'(q_dat.size()), 8);
        for (int i = 0; i < 8 && i < q_dat.size(); i++) begin
            chk($sformatf("t2_dat%0d", i), q_dat[i], exp_t2[i]);
            chk($sformatf("t2_last%0d", i), q_last[i], (i == 3 || i == 7));
        end
        if (q_cyc.size() == 8) chk("t2_span", 64'(q_cyc[7] - q_cyc[0]), 7);
        chk("t2_wc", word_count, 8);
        chk("t2_fc", frame_count, 2);
        chk("t2_len1_wc", word_count1, 8);
        chk("t2_len1_fc", frame_count1, 8);

        // 3: 5-cycle downstream stall mid-stream
        do_reset();
        fork
            begin
                for (int i = 0; i < 6; i++) send_word(16'(100 + i), 16'd3, 1'b0);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                m_if.tready = 1'b0;
                @(negedge clk);
                held_dat  = m_if.tdata;
                held_last = m_if.tlast;
                chk("t3_held_dat", held_dat, 32'd303);
                for (int c = 0; c < 5; c++) begin
                    chk($sformatf("t3_s_rdy%0d", c), s_if.tready, 0);
                    chk($sformatf("t3_vld%0d", c), m_if.tvalid, 1);
                    chk($sformatf("t3_dat%0d", c), m_if.tdata, held_dat);
                    chk($sformatf("t3_last%0d", c), m_if.tlast, held_last);
                    if (c < 4) @(negedge clk);
                end
                @(posedge clk);
                #1;
                m_if.tready = 1'b1;
            end
        join
        wait_out(6);
        repeat (3) @(negedge clk);
        chk("t3_count", 64'(q_dat.size()), 6);
        for (int i = 0; i < 6 && i < q_dat.size(); i++) begin
            chk($sformatf("t3_q%0d", i), q_dat[i], 32'(3 * (100 + i)));
            chk($sformatf("t3_ql%0d", i), q_last[i], (i == 3));
        end
        chk("t3_wc", word_count, 6);

        // 4: early tlast on word 2, next frame full length
        do_reset();
        for (int i = 0; i < 6; i++) send_word(16'(10 + i), 16'd2, (i == 1));
        wait_out(6);
        for (int i = 0; i < 6 && i < q_dat.size(); i++) begin
            chk($sformatf("t4_dat%0d", i), q_dat[i], 32'(20 + 2 * i));
            chk($sformatf("t4_last%0d", i), q_last[i], (i == 1 || i == 5));
        end
        chk("t4_fc", frame_count, 2);

        // 5: sign handling
        do_reset();
`ifdef MULT_SIGNED_EN
        exp5 = 32'hFFFFFFFE;
`else
        exp5 = 32'h0001FFFE;
`endif
        send_word(16'h0002, 16'hFFFF, 1'b0);
        wait_out(1);
        if (q_dat.size() > 0) chk("t5_prod", q_dat[0], exp5);

        // 6: reset with two words in flight
        do_reset();
        for (int i = 0; i < 3; i++) send_word(16'(i + 1), 16'd7, 1'b0);
        chk("t6_wc_before", word_count, 1);
        chk("t6_vld_before", m_if.tvalid, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_vld", m_if.tvalid, 0);
        chk("t6_rst_wc", word_count, 0);
        chk("t6_rst_fc", frame_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear_q();
        for (int i = 0; i < 4; i++) send_word(16'(i + 1), 16'd5, 1'b0);
        wait_out(4);
        for (int i = 0; i < 4 && i < q_dat.size(); i++) begin
            chk($sformatf("t6_dat%0d", i), q_dat[i], 32'(5 * (i + 1)));
            chk($sformatf("t6_last%0d", i), q_last[i], (i == 3));
        end
        chk("t6_wc", word_count, 4);
        chk("t6_fc", frame_count, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
